tl_buffer_param: RTL

Parametrised two-channel TileLink-UL buffer for the tile's uncached memory path, inserted between a TL-UL client and its manager to break timing and absorb bursts. Channel A (client→manager) and channel D (manager→client) each get an independent circular FIFO. Depth, flow-through and pipelined-ready modes are set per channel, and each FIFO's occupancy is exported for debug and drain control.

---
 rtl/tl_buffer_param.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tl_buffer_param.sv
// Two-channel TL-UL buffer: independent circular FIFOs on A (client->manager)
// and D (manager->client), each with its own depth, flow-through and pipe mode.

module tl_buffer_param_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int CW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enqValid,
  output logic             enqReady,
  input  logic [WIDTH-1:0] enqData,
  output logic             deqValid,
  input  logic             deqReady,
  output logic [WIDTH-1:0] deqData,
  output logic [CW-1:0]    count
);

  if (DEPTH == 0) begin : gPass
    assign deqValid = enqValid;
    assign enqReady = deqReady;
    assign deqData  = enqData;
    assign count    = '0;

    logic unusedClockReset;
    assign unusedClockReset = clock ^ reset;
  end else begin : gFifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             isEmpty, isFull, enqFire, deqFire, bypass, doWrite, doRead;

    assign isEmpty  = (cnt == '0);
    assign isFull   = (cnt == FULL);
    assign enqReady = !isFull || ((PIPE != 0) && deqReady);
    assign deqValid = !isEmpty || ((FLOW != 0) && enqValid);
    assign deqData  = ((FLOW != 0) && isEmpty) ? enqData : mem[rp];

    assign enqFire = enqValid && enqReady;
    assign deqFire = deqValid && deqReady;
    // An empty flow-through FIFO hands the beat straight across without storing it.
    assign bypass  = (FLOW != 0) && isEmpty && enqFire && deqFire;
    assign doWrite = enqFire && !bypass;
    assign doRead  = deqFire && !bypass;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (doWrite) wp <= (wp == LAST) ? '0 : wp + 1'b1;
        if (doRead)  rp <= (rp == LAST) ? '0 : rp + 1'b1;
        if (doWrite && !doRead)      cnt <= cnt + 1'b1;
        else if (doRead && !doWrite) cnt <= cnt - 1'b1;
      end
    end

    // NOTE: payload storage has no reset; cnt gates every read, so stale contents are never seen.
    always_ff @(posedge clock) begin
      if (doWrite) mem[wp] <= enqData;
    end

    assign count = cnt;
  end

endmodule

module tl_buffer_param #(
  parameter int ADDR_W  = 36,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = 3,
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int A_FLOW  = 0,
  parameter int A_PIPE  = 0,
  parameter int D_FLOW  = 0,
  parameter int D_PIPE  = 0,
  localparam int CW_A   = (A_DEPTH < 1) ? 1 : $clog2(A_DEPTH + 1),
  localparam int CW_D   = (D_DEPTH < 1) ? 1 : $clog2(D_DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_a_valid,
  output logic                in_a_ready,
  input  logic [2:0]          in_a_opcode,
  input  logic [2:0]          in_a_size,
  input  logic [SRC_W-1:0]    in_a_source,
  input  logic [ADDR_W-1:0]   in_a_address,
  input  logic [DATA_W/8-1:0] in_a_mask,
  input  logic [DATA_W-1:0]   in_a_data,
  output logic                in_d_valid,
  input  logic                in_d_ready,
  output logic [2:0]          in_d_opcode,
  output logic [2:0]          in_d_size,
  output logic [SRC_W-1:0]    in_d_source,
  output logic [DATA_W-1:0]   in_d_data,
  output logic                out_a_valid,
  input  logic                out_a_ready,
  output logic [2:0]          out_a_opcode,
  output logic [2:0]          out_a_size,
  output logic [SRC_W-1:0]    out_a_source,
  output logic [ADDR_W-1:0]   out_a_address,
  output logic [DATA_W/8-1:0] out_a_mask,
  output logic [DATA_W-1:0]   out_a_data,
  input  logic                out_d_valid,
  output logic                out_d_ready,
  input  logic [2:0]          out_d_opcode,
  input  logic [2:0]          out_d_size,
  input  logic [SRC_W-1:0]    out_d_source,
  input  logic [DATA_W-1:0]   out_d_data,
  output logic [CW_A-1:0]     a_count,
  output logic [CW_D-1:0]     d_count,
  output logic                idle
);

  localparam int AW = 6 + SRC_W + ADDR_W + DATA_W / 8 + DATA_W;
  localparam int DW = 6 + SRC_W + DATA_W;

  logic [AW-1:0] aEnq, aDeq;
  logic [DW-1:0] dEnq, dDeq;

  assign aEnq = {in_a_opcode, in_a_size, in_a_source, in_a_address, in_a_mask, in_a_data};
  assign {out_a_opcode, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data} = aDeq;

  assign dEnq = {out_d_opcode, out_d_size, out_d_source, out_d_data};
  assign {in_d_opcode, in_d_size, in_d_source, in_d_data} = dDeq;

  tl_buffer_param_fifo #(
    .WIDTH(AW), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE), .CW(CW_A)
  ) aFifo (
    .clock    (clock),
    .reset    (reset),
    .enqValid (in_a_valid),
    .enqReady (in_a_ready),
    .enqData  (aEnq),
    .deqValid (out_a_valid),
    .deqReady (out_a_ready),
    .deqData  (aDeq),
    .count    (a_count)
  );

  tl_buffer_param_fifo #(
    .WIDTH(DW), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE), .CW(CW_D)
  ) dFifo (
    .clock    (clock),
    .reset    (reset),
    .enqValid (out_d_valid),
    .enqReady (out_d_ready),
    .enqData  (dEnq),
    .deqValid (in_d_valid),
    .deqReady (in_d_ready),
    .deqData  (dDeq),
    .count    (d_count)
  );

  assign idle = (a_count == '0) && (d_count == '0);

endmodule
